onchip_ram_pipelined: RTL

Parametrised Avalon-MM on-chip RAM slave for the Nios II subsystems: single-port, byte-enabled, with a configurable read pipeline (`readdatavalid`), `waitrequest` back-pressure, and a built-in scrubber that fills the array with a constant after reset or on request. It replaces fixed 32-bit × 32K instances where latency, width or deterministic initial contents matter, such as inter-CPU mailboxes and scratch buffers.

---
 rtl/onchip_ram_pkg.sv | 17 +
 rtl/onchip_ram_array.sv | 64 ++++++
 rtl/onchip_ram_pipelined.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/onchip_ram_pkg.sv
// Shared types and constants for the pipelined Avalon-MM on-chip RAM slave.
package onchip_ram_pkg;

    typedef enum logic [1:0] {
        SCRUB = 2'd0,
        DRAIN = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 2;

    function automatic bit legal_width(input int w);
        return (w >= 8) && (w <= 128) && ((w % 8) == 0);
    endfunction

endpackage

// File: rtl/onchip_ram_array.sv
// Single-port byte-enabled RAM with a registered read port and an optional
// second output register; contents are not reset so the array maps to block RAM.
module onchip_ram_array
    import onchip_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 15,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en,
    input  logic                    i_re,
    input  logic [DATA_WIDTH/8-1:0] i_we,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_q1;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Loaded only on an accepted read so the output holds between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q1 <= '0;
        end else if (i_en && i_re) begin
            r_q1 <= r_mem[i_addr];
        end
    end

    generate
        if (READ_LATENCY == LAT_MAX) begin : g_out2
            logic [DATA_WIDTH-1:0] r_q2;

            // r_q1 only changes on accepts, so copying it every advancing cycle
            // updates r_q2 exactly on the edge that raises the valid pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q2 <= '0;
                end else if (i_en) begin
                    r_q2 <= r_q1;
                end
            end

            assign o_rdata = r_q2;
        end else begin : g_out1
            assign o_rdata = r_q1;
        end
    endgenerate

endmodule

// File: rtl/onchip_ram_pipelined.sv
// Avalon-MM on-chip RAM slave: pipelined reads, waitrequest back-pressure,
// and a scrubber that fills the array with a constant after reset or on request.
module onchip_ram_pipelined
    import onchip_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 15,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    SCRUB_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] SCRUB_VALUE    = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    input  logic                    clken,
    input  logic                    reset_req,
    input  logic                    scrub_start,
    output logic                    scrub_busy,
    output logic                    scrub_done
);

    localparam int     BYTES     = DATA_WIDTH / 8;
    localparam state_t RST_STATE = (SCRUB_ON_RESET != 0) ? SCRUB : READY;

    generate
        if (!legal_width(DATA_WIDTH) || (READ_LATENCY < LAT_MIN) || (READ_LATENCY > LAT_MAX)) begin : g_bad_param
            $error("onchip_ram_pipelined: illegal DATA_WIDTH or READ_LATENCY");
        end
    endgenerate

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_scrub_addr;
    logic [ADDR_WIDTH-1:0]   w_scrub_addr_next;
    logic [READ_LATENCY-1:0] r_vpipe;
    logic                    r_done;

    logic                    w_adv;
    logic                    w_scrubbing;
    logic                    w_scrub_last;
    logic                    w_pipe_busy;
    logic                    w_wr_acc;
    logic                    w_rd_acc;
    logic [ADDR_WIDTH-1:0]   w_ram_addr;
    logic [DATA_WIDTH-1:0]   w_ram_wdata;
    logic [BYTES-1:0]        w_ram_we;
    logic [DATA_WIDTH-1:0]   w_ram_rdata;

    assign w_adv        = clken & ~reset_req;
    assign waitrequest  = ~reset_n | ~w_adv | (r_state != READY);
    assign w_wr_acc     = chipselect & write & ~waitrequest;
    assign w_rd_acc     = chipselect & read & ~write & ~waitrequest;
    assign w_scrubbing  = (r_state == SCRUB);
    assign w_scrub_last = w_scrubbing & (r_scrub_addr == {ADDR_WIDTH{1'b1}});
    assign w_pipe_busy  = |r_vpipe;

    // Write-port mux: the scrubber owns the port whenever it is running.
    always_comb begin
        w_ram_addr  = address;
        w_ram_wdata = writedata;
        w_ram_we    = '0;
        if (w_scrubbing) begin
            w_ram_addr  = r_scrub_addr;
            w_ram_wdata = SCRUB_VALUE;
            w_ram_we    = '1;
        end else if (w_wr_acc) begin
            w_ram_we    = byteenable;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_scrub_addr_next = r_scrub_addr;
        case (r_state)
            SCRUB: begin
                if (w_scrub_last) begin
                    w_state_next      = READY;
                    w_scrub_addr_next = '0;
                end else begin
                    w_scrub_addr_next = r_scrub_addr + 1'b1;
                end
            end
            DRAIN: begin
                if (!w_pipe_busy) begin
                    w_state_next = SCRUB;
                end
            end
            READY: begin
                if (scrub_start) begin
                    w_state_next = w_pipe_busy ? DRAIN : SCRUB;
                end
            end
            default: w_state_next = READY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= RST_STATE;
            r_scrub_addr <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_adv & w_scrub_last;
            if (w_adv) begin
                r_state      <= w_state_next;
                r_scrub_addr <= w_scrub_addr_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vpipe <= '0;
        end else if (w_adv) begin
            r_vpipe[0] <= w_rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    onchip_ram_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_array (
        .clk    (clk),
        .rst_n  (reset_n),
        .i_en   (w_adv & reset_n),
        .i_re   (w_rd_acc),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_wdata(w_ram_wdata),
        .o_rdata(w_ram_rdata)
    );

    // A frozen pipe keeps its last stage, so the pulse is only shown while advancing.
    assign readdata      = w_ram_rdata;
    assign readdatavalid = r_vpipe[READ_LATENCY-1] & w_adv;
    assign scrub_busy    = (r_state != READY);
    assign scrub_done    = r_done;

endmodule
